alu_result_display: RTL and testbench

Downstream consumer of the ALU result. It captures the unsigned 6-bit ALU output when the multiplier's done strobe fires, converts it to two BCD digits with a sequential double-dabble, and time-multiplexes the digits onto a 2-digit common-anode 7-segment display. It sits between the ALU `out`/`done` signals and the board display pins.

---
 rtl/alu_result_display.sv | 168 ++++++++++++++++
 tb/tb_alu_result_display.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_display.sv
// ALU result capture, sequential double-dabble to two BCD digits,
// and a multiplexed 2-digit common-anode 7-segment driver.
module alu_result_display #(
    parameter int REFRESH_DIV = 50000,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] result,
    input  logic       valid,
    output logic       busy,
    output logic       ready,
    output logic [3:0] tens,
    output logic [3:0] units,
    output logic [6:0] seg,
    output logic [1:0] an
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT
    } state_e;

    state_e state_q, state_d;

    logic [5:0] bin_q, bin_d;
    logic [7:0] bcd_q, bcd_d, bcd_adj;
    logic [2:0] cnt_q, cnt_d;
    logic [3:0] tens_q, tens_d;
    logic [3:0] units_q, units_d;
    logic       ready_q, ready_d;

    logic [CW-1:0] ref_q, ref_d;
    logic          sel_q, sel_d;
    logic [6:0]    seg_q, seg_d;
    logic [1:0]    an_q, an_d;
    logic [3:0]    digit;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (valid) state_d = SHIFT;
            SHIFT:   if (cnt_q == 3'd5) state_d = COMMIT;
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != IDLE);
    end

    // Add-3 correction on each nibble before the shift.
    always_comb begin
        bcd_adj = bcd_q;
        if (bcd_q[3:0] >= 4'd5) bcd_adj[3:0] = bcd_q[3:0] + 4'd3;
        if (bcd_q[7:4] >= 4'd5) bcd_adj[7:4] = bcd_q[7:4] + 4'd3;
    end

    always_comb begin
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        tens_d  = tens_q;
        units_d = units_q;
        ready_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid) begin
                    bin_d = result;
                    bcd_d = '0;
                    cnt_d = '0;
                end
            end
            SHIFT: begin
                {bcd_d, bin_d} = {bcd_adj[6:0], bin_q, 1'b0};
                cnt_d = cnt_q + 3'd1;
            end
            COMMIT: begin
                tens_d  = bcd_q[7:4];
                units_d = bcd_q[3:0];
                ready_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            tens_q  <= '0;
            units_q <= '0;
            ready_q <= 1'b0;
        end else begin
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            tens_q  <= tens_d;
            units_q <= units_d;
            ready_q <= ready_d;
        end
    end

    always_comb begin
        ref_d = (ref_q == LAST) ? '0 : ref_q + CW'(1);
        sel_d = sel_q ^ (ref_q == LAST);
        digit = sel_q ? tens_q : units_q;
        seg_d = seg_decode(digit);
        an_d  = sel_q ? 2'b01 : 2'b10;
        if (BLANK_LZ && sel_q && (tens_q == 4'd0)) begin
            an_d  = 2'b11;
            seg_d = 7'b1111111;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ref_q <= '0;
            sel_q <= 1'b0;
            seg_q <= 7'b1000000;
            an_q  <= 2'b10;
        end else begin
            ref_q <= ref_d;
            sel_q <= sel_d;
            seg_q <= seg_d;
            an_q  <= an_d;
        end
    end

    assign ready = ready_q;
    assign tens  = tens_q;
    assign units = units_q;
    assign seg   = seg_q;
    assign an    = an_q;

endmodule

// File: tb/tb_alu_result_display.sv
// Scoreboard bench for alu_result_display: conversion, latency,
// strobe handling, async abort and display multiplexing.
module tb_alu_result_display;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] result = '0;
    logic       valid = 1'b0;

    logic       busy_b, ready_b;
    logic [3:0] tens_b, units_b;
    logic [6:0] seg_b;
    logic [1:0] an_b;

    logic       busy_n, ready_n;
    logic [3:0] tens_n, units_n;
    logic [6:0] seg_n;
    logic [1:0] an_n;

    int n_run = 0;
    int n_fail = 0;
    logic [7:0] sb[$];
    logic [6:0] segt[10];

    always #5 clk = ~clk;

    alu_result_display #(.REFRESH_DIV(4), .BLANK_LZ(1'b1)) u_b (
        .clk(clk), .rst(rst), .result(result), .valid(valid),
        .busy(busy_b), .ready(ready_b), .tens(tens_b),
        .units(units_b), .seg(seg_b), .an(an_b)
    );

    alu_result_display #(.REFRESH_DIV(4), .BLANK_LZ(1'b0)) u_n (
        .clk(clk), .rst(rst), .result(result), .valid(valid),
        .busy(busy_n), .ready(ready_n), .tens(tens_n),
        .units(units_n), .seg(seg_n), .an(an_n)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    task automatic start(input logic [5:0] r, input bit push);
        @(negedge clk);
        result = r;
        valid  = 1'b1;
        if (push) sb.push_back({4'(r / 10), 4'(r % 10)});
        @(negedge clk);
        valid = 1'b0;
    endtask

    // Called at the negedge after the capture edge.
    task automatic wait_ready(output int lat, output int bcyc);
        lat  = 1;
        bcyc = busy_b ? 1 : 0;
        while (!ready_b && lat < 20) begin
            @(negedge clk);
            lat++;
            if (busy_b) bcyc++;
        end
    endtask

    task automatic wait_an(input bit inst_n, input logic [1:0] v,
                           output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 24; i++) begin
            if ((inst_n ? an_n : an_b) === v) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        logic [1:0] ea, ean;
        logic [6:0] es;
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        n_run++;
        if ({busy_b, ready_b, tens_b, units_b, an_b, seg_b} !==
            {1'b0, 1'b0, 4'd0, 4'd0, 2'b10, 7'b1000000}) begin
            n_fail++;
            $display("FAIL reset_state: got b%b r%b %0d/%0d an%b seg%b",
                     busy_b, ready_b, tens_b, units_b, an_b, seg_b);
        end
        rst = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            ea  = (((k - 1) / 4) % 2) ? 2'b11 : 2'b10;
            ean = (((k - 1) / 4) % 2) ? 2'b01 : 2'b10;
            es  = (ea == 2'b10) ? 7'b1000000 : 7'b1111111;
            n_run++;
            if (an_b !== ea || seg_b !== es) begin
                n_fail++;
                $display("FAIL idle_mux k=%0d: an %b seg %b want %b %b",
                         k, an_b, seg_b, ea, es);
            end
            n_run++;
            if (an_n !== ean || seg_n !== 7'b1000000) begin
                n_fail++;
                $display("FAIL idle_mux_nb k=%0d: an %b seg %b want %b",
                         k, an_n, seg_n, ean);
            end
            n_run++;
            if (ready_b !== 1'b0 || {tens_b, units_b} !== 8'h00) begin
                n_fail++;
                $display("FAIL idle_digits k=%0d: r%b %0d/%0d want 0 0/0",
                         k, ready_b, tens_b, units_b);
            end
        end
    endtask

    task automatic test_49();
        int lat, bc;
        bit ok;
        logic [7:0] e;
        start(6'd49, 1'b1);
        wait_ready(lat, bc);
        n_run++;
        if (lat != 8 || bc != 7) begin
            n_fail++;
            $display("FAIL lat49: lat %0d busy %0d want 8 7", lat, bc);
        end
        n_run++;
        if (!ready_b || sb.size() == 0) begin
            n_fail++;
            $display("FAIL conv49: no ready or empty queue");
        end else begin
            e = sb.pop_front();
            if ({tens_b, units_b} !== e) begin
                n_fail++;
                $display("FAIL conv49: got %0d/%0d want %0d/%0d",
                         tens_b, units_b, e[7:4], e[3:0]);
            end
        end
        @(negedge clk);
        @(negedge clk);
        wait_an(1'b0, 2'b01, ok);
        n_run++;
        if (!ok || seg_b !== 7'b0011001) begin
            n_fail++;
            $display("FAIL disp49_tens: ok %0b seg %b want 0011001",
                     ok, seg_b);
        end
        wait_an(1'b0, 2'b10, ok);
        n_run++;
        if (!ok || seg_b !== 7'b0010000) begin
            n_fail++;
            $display("FAIL disp49_units: ok %0b seg %b want 0010000",
                     ok, seg_b);
        end
    endtask

    task automatic test_sequence();
        logic [5:0] vals[3];
        logic [1:0] wan[3];
        logic [6:0] wseg[3];
        int lat, bc;
        bit ok;
        logic [7:0] e;
        vals = '{6'd63, 6'd0, 6'd10};
        wan  = '{2'b01, 2'b11, 2'b01};
        wseg = '{segt[6], 7'b1111111, segt[1]};
        for (int i = 0; i < 3; i++) begin
            start(vals[i], 1'b1);
            wait_ready(lat, bc);
            n_run++;
            if (!ready_b || sb.size() == 0) begin
                n_fail++;
                $display("FAIL seq_%0d: no ready", vals[i]);
            end else begin
                e = sb.pop_front();
                if ({tens_b, units_b} !== e) begin
                    n_fail++;
                    $display("FAIL seq_%0d: got %0d/%0d want %0d/%0d",
                             vals[i], tens_b, units_b, e[7:4], e[3:0]);
                end
            end
            @(negedge clk);
            @(negedge clk);
            wait_an(1'b0, wan[i], ok);
            n_run++;
            if (!ok || seg_b !== wseg[i]) begin
                n_fail++;
                $display("FAIL seq_disp_%0d: ok %0b seg %b want %b",
                         vals[i], ok, seg_b, wseg[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        logic [7:0] e;
        start(6'd0, 1'b1);
        for (int v = 0; v < 64; v++) begin
            wait_ready(lat, bc);
            n_run++;
            if (!ready_b || lat != 8 || sb.size() == 0) begin
                n_fail++;
                $display("FAIL sweep_%0d: ready %b lat %0d", v, ready_b, lat);
            end else begin
                e = sb.pop_front();
                if (tens_b !== 4'(v / 10) || units_b !== 4'(v % 10)
                    || {tens_b, units_b} !== e) begin
                    n_fail++;
                    $display("FAIL sweep_%0d: got %0d/%0d want %0d/%0d",
                             v, tens_b, units_b, v / 10, v % 10);
                end
            end
            if (v < 63) begin
                result = 6'(v + 1);
                valid  = 1'b1;
                sb.push_back({4'((v + 1) / 10), 4'((v + 1) % 10)});
                @(negedge clk);
                valid = 1'b0;
            end
        end
    endtask

    task automatic test_ignore_busy();
        int pulses = 0;
        logic [7:0] e;
        start(6'd35, 1'b1);
        @(negedge clk);
        result = 6'd12;
        valid  = 1'b1;
        @(negedge clk);
        valid  = 1'b0;
        result = 6'd0;
        for (int i = 0; i < 24; i++) begin
            if (ready_b) begin
                pulses++;
                if (pulses == 1 && sb.size() != 0) begin
                    e = sb.pop_front();
                    n_run++;
                    if ({tens_b, units_b} !== e) begin
                        n_fail++;
                        $display("FAIL ignore_digits: got %0d/%0d want %0d/%0d",
                                 tens_b, units_b, e[7:4], e[3:0]);
                    end
                end
            end
            @(negedge clk);
        end
        n_run++;
        if (pulses != 1 || {tens_b, units_b} !== 8'h35) begin
            n_fail++;
            $display("FAIL ignore_pulses: %0d pulses %0d/%0d want 1 3/5",
                     pulses, tens_b, units_b);
        end
    endtask

    task automatic test_reset_abort();
        int pulses = 0;
        start(6'd42, 1'b0);
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        n_run++;
        if ({busy_b, ready_b, tens_b, units_b, an_b, seg_b} !==
            {1'b0, 1'b0, 4'd0, 4'd0, 2'b10, 7'b1000000}) begin
            n_fail++;
            $display("FAIL abort_async: got b%b r%b %0d/%0d an%b seg%b",
                     busy_b, ready_b, tens_b, units_b, an_b, seg_b);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (ready_b) pulses++;
        end
        n_run++;
        if (pulses != 0 || {tens_b, units_b} !== 8'h00 || busy_b) begin
            n_fail++;
            $display("FAIL abort_after: %0d pulses %0d/%0d busy %b",
                     pulses, tens_b, units_b, busy_b);
        end
    endtask

    task automatic test_no_blank();
        int lat, bc;
        bit ok;
        logic [7:0] e;
        start(6'd7, 1'b1);
        wait_ready(lat, bc);
        n_run++;
        if (!ready_n || sb.size() == 0) begin
            n_fail++;
            $display("FAIL nb_conv: no ready");
        end else begin
            e = sb.pop_front();
            if ({tens_n, units_n} !== e) begin
                n_fail++;
                $display("FAIL nb_conv: got %0d/%0d want %0d/%0d",
                         tens_n, units_n, e[7:4], e[3:0]);
            end
        end
        @(negedge clk);
        @(negedge clk);
        wait_an(1'b1, 2'b01, ok);
        n_run++;
        if (!ok || seg_n !== 7'b1000000) begin
            n_fail++;
            $display("FAIL nb_tens: ok %0b seg %b want 1000000", ok, seg_n);
        end
        wait_an(1'b1, 2'b10, ok);
        n_run++;
        if (!ok || seg_n !== 7'b1111000) begin
            n_fail++;
            $display("FAIL nb_units: ok %0b seg %b want 1111000", ok, seg_n);
        end
    endtask

    initial begin
        segt = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                 7'b0000000, 7'b0010000};
        test_reset();
        test_49();
        test_sequence();
        test_back_to_back();
        test_ignore_busy();
        test_reset_abort();
        test_no_blank();
        n_run++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d left want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
